// File: rtl/adc_conv_scheduler.sv
// AD7323 conversion scheduler: time-shares the converter between the fast (ch0/ch2) and slow (ch1/ch3)
// pairs, demuxes tagged results and flags faults. Define ADC_SCHED_AVG_EN for 4-sample ch1/ch3 averaging.
module adc_conv_scheduler #(
    parameter int FAST_PAIRS  = 8,
    parameter int SLOW_PAIRS  = 1,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               clk14MHz,
    input  logic               rst,
    input  logic               sched_en,
    input  logic               adc_done,
    input  logic [1:0]         adc_channel,
    input  logic signed [12:0] adc_data,
    output logic               standby,
    output logic signed [12:0] ch0,
    output logic signed [12:0] ch1,
    output logic signed [12:0] ch2,
    output logic signed [12:0] ch3,
    output logic [3:0]         ch_valid,
    output logic               vi_valid,
    output logic               err_seq,
    output logic               err_timeout
);
    // state   | meaning
    // ST_FAST | standby=0, converter runs the ch0/ch2 pair
    // ST_SLOW | standby=1, converter runs the ch1/ch3 pair
    typedef enum logic {ST_FAST = 1'b0, ST_SLOW = 1'b1} state_t;

    localparam int MAXP = (FAST_PAIRS > SLOW_PAIRS) ? FAST_PAIRS : SLOW_PAIRS;
    localparam int PW   = $clog2(MAXP + 1);
    localparam int TW   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [PW-1:0] FAST_LAST = PW'(FAST_PAIRS - 1);
    localparam logic [PW-1:0] SLOW_LAST = PW'(SLOW_PAIRS - 1);
    localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT_CYC);

    state_t             state_q, state_d;
    logic [PW-1:0]      pair_cnt_q, pair_cnt_d;
    logic               done_q;
    logic               done_rise, pair_end, slow_ok;
    logic signed [12:0] fast_q [2];
    logic signed [12:0] fast_d [2];
    logic signed [12:0] slow_out [2];
    logic [3:0]         ch_valid_q, ch_valid_d;
    logic               vi_valid_q, vi_valid_d;
    logic               ch0_seen_q, ch0_seen_d;
    logic               prev_tag1_q, prev_tag1_d;
    logic               tag_seen_q, tag_seen_d;
    logic               err_seq_q, err_seq_d;
    logic [TW-1:0]      tmo_cnt_q, tmo_cnt_d;
    logic               err_timeout_q, err_timeout_d;

    assign done_rise = adc_done & ~done_q;
    assign pair_end  = done_rise & adc_channel[1];

    always_comb begin
        state_d       = state_q;
        pair_cnt_d    = pair_cnt_q;
        fast_d        = fast_q;
        ch_valid_d    = '0;
        vi_valid_d    = 1'b0;
        ch0_seen_d    = ch0_seen_q;
        prev_tag1_d   = prev_tag1_q;
        tag_seen_d    = tag_seen_q;
        err_seq_d     = err_seq_q;
        tmo_cnt_d     = tmo_cnt_q;
        err_timeout_d = err_timeout_q;

        // Disabling the schedule overrides any pair end in the same cycle.
        if (!sched_en) begin
            state_d    = ST_FAST;
            pair_cnt_d = '0;
        end else if (pair_end) begin
            unique case (state_q)
                ST_FAST: begin
                    if (pair_cnt_q == FAST_LAST) begin
                        state_d    = ST_SLOW;
                        pair_cnt_d = '0;
                    end else begin
                        pair_cnt_d = pair_cnt_q + 1'b1;
                    end
                end
                ST_SLOW: begin
                    if (pair_cnt_q == SLOW_LAST) begin
                        state_d    = ST_FAST;
                        pair_cnt_d = '0;
                    end else begin
                        pair_cnt_d = pair_cnt_q + 1'b1;
                    end
                end
            endcase
        end

        if (done_rise) begin
            ch_valid_d[adc_channel] = slow_ok;
            if (!adc_channel[0]) fast_d[adc_channel[1]] = adc_data;
            vi_valid_d = (adc_channel == 2'd2) && ch0_seen_q;
            if (adc_channel[1]) ch0_seen_d = 1'b0;
            else if (adc_channel == 2'd0) ch0_seen_d = 1'b1;
            if (tag_seen_q && (adc_channel[1] == prev_tag1_q)) err_seq_d = 1'b1;
            prev_tag1_d = adc_channel[1];
            tag_seen_d  = 1'b1;
        end

        if (done_rise) tmo_cnt_d = '0;
        else if (tmo_cnt_q != TMO_MAX) tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (tmo_cnt_d == TMO_MAX) err_timeout_d = 1'b1;
    end

    always_ff @(posedge clk14MHz) begin
        done_q <= adc_done;
        if (rst) begin
            state_q       <= ST_FAST;
            pair_cnt_q    <= '0;
            fast_q        <= '{default: '0};
            ch_valid_q    <= '0;
            vi_valid_q    <= 1'b0;
            ch0_seen_q    <= 1'b0;
            prev_tag1_q   <= 1'b0;
            tag_seen_q    <= 1'b0;
            err_seq_q     <= 1'b0;
            tmo_cnt_q     <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pair_cnt_q    <= pair_cnt_d;
            fast_q        <= fast_d;
            ch_valid_q    <= ch_valid_d;
            vi_valid_q    <= vi_valid_d;
            ch0_seen_q    <= ch0_seen_d;
            prev_tag1_q   <= prev_tag1_d;
            tag_seen_q    <= tag_seen_d;
            err_seq_q     <= err_seq_d;
            tmo_cnt_q     <= tmo_cnt_d;
            err_timeout_q <= err_timeout_d;
        end
    end

`ifdef ADC_SCHED_AVG_EN
    // hist[s][0] is the newest sample; slow index 0 = ch1, 1 = ch3.
    logic signed [12:0] hist_q [2][4];
    logic signed [12:0] hist_d [2][4];
    logic [2:0]         nsamp_q [2];
    logic [2:0]         nsamp_d [2];
    logic signed [14:0] sum [2];

    always_comb begin
        hist_d  = hist_q;
        nsamp_d = nsamp_q;
        slow_ok = 1'b1;
        if (done_rise && adc_channel[0]) begin
            for (int i = 3; i > 0; i--) hist_d[adc_channel[1]][i] = hist_q[adc_channel[1]][i-1];
            hist_d[adc_channel[1]][0] = adc_data;
            if (nsamp_q[adc_channel[1]] != 3'd4) nsamp_d[adc_channel[1]] = nsamp_q[adc_channel[1]] + 3'd1;
            slow_ok = (nsamp_d[adc_channel[1]] == 3'd4);
        end
    end

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            sum[s] = {{2{hist_q[s][0][12]}}, hist_q[s][0]} + {{2{hist_q[s][1][12]}}, hist_q[s][1]}
                   + {{2{hist_q[s][2][12]}}, hist_q[s][2]} + {{2{hist_q[s][3][12]}}, hist_q[s][3]};
            slow_out[s] = sum[s][14:2];
        end
    end

    always_ff @(posedge clk14MHz) begin
        if (rst) begin
            hist_q  <= '{default: '0};
            nsamp_q <= '{default: '0};
        end else begin
            hist_q  <= hist_d;
            nsamp_q <= nsamp_d;
        end
    end
`else
    logic signed [12:0] slow_q [2];
    logic signed [12:0] slow_d [2];

    assign slow_ok = 1'b1;

    always_comb begin
        slow_d = slow_q;
        if (done_rise && adc_channel[0]) slow_d[adc_channel[1]] = adc_data;
    end

    always_ff @(posedge clk14MHz) begin
        if (rst) slow_q <= '{default: '0};
        else     slow_q <= slow_d;
    end

    assign slow_out = slow_q;
`endif

    assign standby     = (state_q == ST_SLOW);
    assign ch0         = fast_q[0];
    assign ch2         = fast_q[1];
    assign ch1         = slow_out[0];
    assign ch3         = slow_out[1];
    assign ch_valid    = ch_valid_q;
    assign vi_valid    = vi_valid_q;
    assign err_seq     = err_seq_q;
    assign err_timeout = err_timeout_q;
endmodule

// File: tb/tb_adc_conv_scheduler.sv
// Scoreboard bench for adc_conv_scheduler; expectations are queued when a conversion is driven.
module tb_adc_conv_scheduler;
    localparam int FAST_PAIRS = 8;
    localparam int SLOW_PAIRS = 1;

    logic clk14MHz = 1'b0;
    logic rst = 1'b1, sched_en = 1'b1, adc_done = 1'b0;
    logic [1:0] adc_channel = '0;
    logic signed [12:0] adc_data = '0;
    logic standby, vi_valid, err_seq, err_timeout;
    logic signed [12:0] ch0, ch1, ch2, ch3;
    logic [3:0] ch_valid;

    adc_conv_scheduler #(.FAST_PAIRS(FAST_PAIRS), .SLOW_PAIRS(SLOW_PAIRS), .TIMEOUT_CYC(64)) dut (
        .clk14MHz(clk14MHz), .rst(rst), .sched_en(sched_en), .adc_done(adc_done),
        .adc_channel(adc_channel), .adc_data(adc_data), .standby(standby),
        .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3), .ch_valid(ch_valid),
        .vi_valid(vi_valid), .err_seq(err_seq), .err_timeout(err_timeout));

    always #5 clk14MHz = ~clk14MHz;

    typedef struct {
        logic [3:0] valid;
        logic [1:0] tag;
        logic signed [12:0] val;
        logic vi;
        logic stby;
        logic err;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int checks = 0, failures = 0;
    logic [19:0] obs, expv;

    bit m_slow, m_seen0, m_first, m_prev, m_err;
    int m_cnt;
    int m_hist[2][4];
    int m_n[2];

    function automatic logic signed [12:0] ch_of(input logic [1:0] t);
        case (t)
            2'd0: return ch0;
            2'd1: return ch1;
            2'd2: return ch2;
            default: return ch3;
        endcase
    endfunction

    task automatic model_reset();
        m_slow = 0; m_seen0 = 0; m_first = 1; m_prev = 0; m_err = 0; m_cnt = 0;
        for (int s = 0; s < 2; s++) begin
            m_n[s] = 0;
            for (int i = 0; i < 4; i++) m_hist[s][i] = 0;
        end
        sbq.delete();
    endtask

    task automatic do_reset();
        @(negedge clk14MHz);
        rst = 1'b1; adc_done = 1'b0;
        repeat (3) @(negedge clk14MHz);
        rst = 1'b0;
        model_reset();
    endtask

    // One conversion: done high for a single cycle; returns on the negedge where its result is visible.
    task automatic send(input logic [1:0] tag, input logic signed [12:0] data);
        exp_t x;
        int sum, s;
        @(negedge clk14MHz);
        adc_channel = tag; adc_data = data; adc_done = 1'b1;
        x.tag = tag; x.valid = 4'b0001 << tag; x.val = data;
`ifdef ADC_SCHED_AVG_EN
        if (tag[0]) begin
            s = int'(tag[1]);
            for (int i = 3; i > 0; i--) m_hist[s][i] = m_hist[s][i-1];
            m_hist[s][0] = int'(data);
            if (m_n[s] < 4) m_n[s]++;
            sum = m_hist[s][0] + m_hist[s][1] + m_hist[s][2] + m_hist[s][3];
            x.val = 13'(sum >>> 2);
            if (m_n[s] < 4) x.valid = 4'b0000;
        end
`endif
        x.vi = (tag == 2'd2) && m_seen0;
        if (tag[1]) m_seen0 = 0; else if (tag == 2'd0) m_seen0 = 1;
        if (!m_first && (tag[1] == m_prev)) m_err = 1;
        m_first = 0; m_prev = tag[1];
        x.err = m_err;
        if (!sched_en) begin
            m_slow = 0; m_cnt = 0;
        end else if (tag[1]) begin
            if (!m_slow) begin
                if (m_cnt == FAST_PAIRS - 1) begin m_slow = 1; m_cnt = 0; end else m_cnt++;
            end else begin
                if (m_cnt == SLOW_PAIRS - 1) begin m_slow = 0; m_cnt = 0; end else m_cnt++;
            end
        end
        x.stby = m_slow;
        sbq.push_back(x);
        @(negedge clk14MHz);
        adc_done = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({standby, ch0, ch1, ch2, ch3, ch_valid, vi_valid, err_seq, err_timeout} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got stby=%0b ch=%0d/%0d/%0d/%0d v=%b vi=%0b es=%0b et=%0b, want all 0",
                     standby, ch0, ch1, ch2, ch3, ch_valid, vi_valid, err_seq, err_timeout);
        end
        repeat (63) @(negedge clk14MHz);
        checks++;
        if (err_timeout !== 1'b0) begin failures++; $display("FAIL timeout_63: got %0b want 0", err_timeout); end
        @(negedge clk14MHz);
        checks++;
        if (err_timeout !== 1'b1) begin failures++; $display("FAIL timeout_64: got %0b want 1", err_timeout); end
        repeat (20) @(negedge clk14MHz);
        checks++;
        if (err_timeout !== 1'b1) begin failures++; $display("FAIL timeout_sticky: got %0b want 1", err_timeout); end
        do_reset();
        checks++;
        if (err_timeout !== 1'b0) begin failures++; $display("FAIL timeout_rst_clear: got %0b want 0", err_timeout); end
        repeat (63) @(negedge clk14MHz);
        adc_channel = 2'd0; adc_data = 13'sd33; adc_done = 1'b1;
        @(negedge clk14MHz);
        adc_done = 1'b0;
        checks++;
        if ({err_timeout, ch_valid} !== 5'b0_0001) begin
            failures++; $display("FAIL timeout_done_same_cycle: got et=%0b v=%b want et=0 v=0001", err_timeout, ch_valid);
        end
        repeat (10) @(negedge clk14MHz);
        checks++;
        if (err_timeout !== 1'b0) begin failures++; $display("FAIL timeout_after_done: got %0b want 0", err_timeout); end
    endtask

    task automatic test_fast_sched();
        int vi_cnt = 0;
        logic [1:0] tags[4] = '{2'd0, 2'd2, 2'd1, 2'd3};
        logic signed [12:0] vals[4] = '{13'sd100, -13'sd200, 13'sd7, 13'sd9};
        do_reset();
        sched_en = 1'b1;
        for (int k = 0; k < 2 * FAST_PAIRS + 2; k++) begin
            int j = (k < 2 * FAST_PAIRS) ? (k % 2) : (k - 2 * FAST_PAIRS + 2);
            send(tags[j], vals[j]);
            if (vi_valid === 1'b1) vi_cnt++;
            e = sbq.pop_front();
            obs  = {ch_valid, ch_of(e.tag), vi_valid, standby, err_seq};
            expv = {e.valid, e.val, e.vi, e.stby, e.err};
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL fast_sched[%0d]: got v=%b ch=%0d vi=%0b stby=%0b es=%0b, want v=%b ch=%0d vi=%0b stby=%0b es=%0b",
                         k, ch_valid, ch_of(e.tag), vi_valid, standby, err_seq, e.valid, e.val, e.vi, e.stby, e.err);
            end
        end
        checks++;
        if (vi_cnt != FAST_PAIRS) begin failures++; $display("FAIL vi_count: got %0d want %0d", vi_cnt, FAST_PAIRS); end
    endtask

    task automatic test_sched_disable();
        do_reset();
        sched_en = 1'b1;
        for (int k = 0; k < 4 * FAST_PAIRS; k++) begin
            if (k == 2 * FAST_PAIRS - 1) sched_en = 1'b0;
            send((k % 2 == 0) ? 2'd0 : 2'd2, 13'(k * 3 - 40));
            sched_en = 1'b1;
            e = sbq.pop_front();
            obs  = {ch_valid, ch_of(e.tag), vi_valid, standby, err_seq};
            expv = {e.valid, e.val, e.vi, e.stby, e.err};
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL sched_disable[%0d]: got v=%b ch=%0d vi=%0b stby=%0b es=%0b, want v=%b ch=%0d vi=%0b stby=%0b es=%0b",
                         k, ch_valid, ch_of(e.tag), vi_valid, standby, err_seq, e.valid, e.val, e.vi, e.stby, e.err);
            end
            if (k == 2 * FAST_PAIRS - 1) begin
                checks++;
                if (standby !== 1'b0) begin failures++; $display("FAIL sched_disable_8th: got stby=%0b want 0", standby); end
            end
        end
        checks++;
        if (standby !== 1'b1) begin failures++; $display("FAIL sched_reenable_slow: got stby=%0b want 1", standby); end
    endtask

    task automatic test_err_seq();
        logic [1:0] tags[5] = '{2'd0, 2'd2, 2'd2, 2'd0, 2'd3};
        for (int k = 0; k < 5; k++) begin
            if (k == 0 || k == 3) do_reset();
            send(tags[k], 13'(-7 * k - 1));
            e = sbq.pop_front();
            obs  = {ch_valid, ch_of(e.tag), vi_valid, standby, err_seq};
            expv = {e.valid, e.val, e.vi, e.stby, e.err};
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL err_seq[%0d]: got v=%b ch=%0d vi=%0b stby=%0b es=%0b, want v=%b ch=%0d vi=%0b stby=%0b es=%0b",
                         k, ch_valid, ch_of(e.tag), vi_valid, standby, err_seq, e.valid, e.val, e.vi, e.stby, e.err);
            end
            if (k == 2) begin
                checks++;
                if (err_seq !== 1'b1) begin failures++; $display("FAIL err_seq_repeat: got %0b want 1", err_seq); end
            end
            if (k == 4) begin
                checks++;
                if (err_seq !== 1'b0) begin failures++; $display("FAIL err_seq_lag: got %0b want 0", err_seq); end
            end
        end
    endtask

    task automatic test_slow_samples();
        logic signed [12:0] vals[5] = '{13'sd4, 13'sd8, 13'sd12, -13'sd5, 13'sd1};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            send(2'd1, vals[k]);
            e = sbq.pop_front();
            obs  = {ch_valid, ch_of(e.tag), vi_valid, standby, err_seq};
            expv = {e.valid, e.val, e.vi, e.stby, e.err};
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL slow_samples[%0d]: got v=%b ch=%0d vi=%0b stby=%0b es=%0b, want v=%b ch=%0d vi=%0b stby=%0b es=%0b",
                         k, ch_valid, ch_of(e.tag), vi_valid, standby, err_seq, e.valid, e.val, e.vi, e.stby, e.err);
            end
`ifdef ADC_SCHED_AVG_EN
            if (k >= 3) begin
                checks++;
                if (ch1 !== 13'sd4) begin failures++; $display("FAIL avg_value[%0d]: got %0d want 4", k, ch1); end
            end
`endif
        end
    endtask

    task automatic test_rst_mid_conv();
        do_reset();
        send(2'd0, 13'sd77);
        e = sbq.pop_front();
        checks++;
        if (ch0 !== 13'sd77) begin failures++; $display("FAIL pre_rst_ch0: got %0d want 77", ch0); end
        @(negedge clk14MHz);
        rst = 1'b1; adc_channel = 2'd2; adc_data = 13'sd55; adc_done = 1'b1;
        @(negedge clk14MHz);
        rst = 1'b0; adc_done = 1'b0;
        model_reset();
        checks++;
        if ({ch_valid, ch0, ch2, vi_valid, standby} !== '0) begin
            failures++;
            $display("FAIL rst_mid_conv: got v=%b ch0=%0d ch2=%0d vi=%0b stby=%0b want all 0", ch_valid, ch0, ch2, vi_valid, standby);
        end
        @(negedge clk14MHz);
        checks++;
        if ({ch_valid, ch2} !== '0) begin
            failures++; $display("FAIL rst_mid_conv_late: got v=%b ch2=%0d want 0", ch_valid, ch2);
        end
    endtask

    task automatic test_done_held();
        do_reset();
        @(negedge clk14MHz);
        adc_channel = 2'd0; adc_data = -13'sd9; adc_done = 1'b1;
        @(negedge clk14MHz);
        checks++;
        if ({ch_valid, ch0} !== {4'b0001, -13'sd9}) begin
            failures++; $display("FAIL done_held_first: got v=%b ch0=%0d want v=0001 ch0=-9", ch_valid, ch0);
        end
        repeat (2) @(negedge clk14MHz);
        checks++;
        if (ch_valid !== 4'b0000) begin failures++; $display("FAIL done_held_single: got v=%b want 0000", ch_valid); end
        adc_done = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fast_sched();
        test_sched_disable();
        test_err_seq();
        test_slow_samples();
        test_rst_mid_conv();
        test_done_held();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
